// File: rtl/timer_ch_sequencer.sv
// -----------------------------------------------------------------------------
// timer_ch_sequencer
//
// Control sequencer for one advanced-timer instance. Decodes software command
// pulses and an optional external trigger. Generates the active, update and
// reset strobes for the timer counter and its NUM_CH output comparators.
// Compare-register updates are applied either immediately or at the next
// timer period end (shadowed). One-shot operation is also supported.
//
// Ports
//   clk_i            clock
//   rst_i            synchronous reset, active-high
//   cmd_start_i      start pulse
//   cmd_stop_i       stop pulse
//   cmd_update_i     update request pulse
//   cmd_reset_i      counter/comparator reset pulse
//   cfg_upd_mask_i   channels affected by cmd_update_i
//   cfg_upd_sync_i   0 = immediate update, 1 = update at timer end
//   cfg_trig_en_i    start waits for the external trigger
//   cfg_oneshot_i    stop automatically after the first timer end
//   ext_trig_i       asynchronous external trigger
//   timer_end_i      counter end-of-period flag
//   timer_valid_i    counter tick qualifier
//   ctrl_active_o    counter/comparators enabled (RUN only)
//   ctrl_update_o    per-channel update strobe, one cycle
//   ctrl_rst_o       counter/comparator reset strobe, one cycle
//   status_state_o   0 IDLE, 1 WAIT_TRIG, 2 LOAD, 3 RUN
//   status_pending_o shadow update pending per channel
//
// Every output is a flop. The next value of each output is derived from the
// next-state logic, so a cause on the inputs appears one cycle later.
// -----------------------------------------------------------------------------
module timer_ch_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_start_i,
  input  logic              cmd_stop_i,
  input  logic              cmd_update_i,
  input  logic              cmd_reset_i,
  input  logic [NUM_CH-1:0] cfg_upd_mask_i,
  input  logic              cfg_upd_sync_i,
  input  logic              cfg_trig_en_i,
  input  logic              cfg_oneshot_i,
  input  logic              ext_trig_i,
  input  logic              timer_end_i,
  input  logic              timer_valid_i,
  output logic              ctrl_active_o,
  output logic [NUM_CH-1:0] ctrl_update_o,
  output logic              ctrl_rst_o,
  output logic [1:0]        status_state_o,
  output logic [NUM_CH-1:0] status_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_LOAD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_trig_prev;
  logic [NUM_CH-1:0]      r_pend;
  logic [NUM_CH-1:0]      r_upd;
  logic                   r_rst;
  logic                   r_active;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t            w_next_state;
  logic [NUM_CH-1:0] w_pend_next;
  logic [NUM_CH-1:0] w_upd_next;
  logic              w_rst_next;
  logic              w_active_next;
  logic              w_enter_load;

  logic              w_trig;
  logic              w_tick_end;
  logic              w_do_reset;
  logic              w_do_stop;
  logic              w_do_start;
  logic              w_do_update;
  logic [NUM_CH-1:0] w_mask_eff;

  // Rising edge of the synchronised trigger.
  assign w_trig     = r_sync[SYNC_STAGES-1] & ~r_trig_prev;
  assign w_tick_end = timer_valid_i & timer_end_i;

  // Command priority: reset > stop > start > update. Reset and update are the
  // one pair allowed to act together, so update is only masked by stop/start.
  assign w_do_reset  = cmd_reset_i;
  assign w_do_stop   = cmd_stop_i  & ~cmd_reset_i;
  assign w_do_start  = cmd_start_i & ~cmd_reset_i & ~cmd_stop_i;
  assign w_do_update = cmd_update_i & ~cmd_stop_i & ~cmd_start_i;
  assign w_mask_eff  = w_do_update ? cfg_upd_mask_i : '0;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_pend_next  = r_pend;
    w_upd_next   = '0;

    unique case (r_state)
      ST_IDLE: begin
        w_pend_next = '0;
        if (w_do_start) begin
          w_next_state = cfg_trig_en_i ? ST_WAIT_TRIG : ST_LOAD;
        end
      end

      ST_WAIT_TRIG: begin
        w_pend_next = '0;
        if (w_do_stop) begin
          w_next_state = ST_IDLE;
        end else if (w_trig) begin
          w_next_state = ST_LOAD;
        end
      end

      ST_LOAD: begin
        w_pend_next  = '0;
        w_next_state = ST_RUN;
      end

      ST_RUN: begin
        if (w_do_stop) begin
          // Stop wins over a coincident timer end; pending work is dropped.
          w_next_state = ST_IDLE;
          w_pend_next  = '0;
        end else begin
          // A timer end flushes the shadow set together with any update that
          // arrives in the same cycle. Immediate mode also flushes leftovers
          // from a previous shadowed phase.
          if (w_tick_end || !cfg_upd_sync_i) begin
            w_upd_next  = r_pend | w_mask_eff;
            w_pend_next = '0;
          end else begin
            w_pend_next = r_pend | w_mask_eff;
          end
          if (cfg_oneshot_i && w_tick_end) begin
            w_next_state = ST_IDLE;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
        w_pend_next  = '0;
      end
    endcase

    // LOAD is only ever entered from another state, never held.
    w_enter_load = (w_next_state == ST_LOAD);
    if (w_enter_load) begin
      w_upd_next = '1;
    end

    // LOAD already emits a reset strobe. A cmd_reset seen during LOAD is
    // folded into that pulse instead of extending it by a cycle.
    w_rst_next    = w_enter_load | (w_do_reset & (r_state != ST_LOAD));
    w_active_next = (w_next_state == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments model all flops updating together on the
    // edge. Blocking assignments here would let one flop see another's new
    // value in the same cycle.
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_sync      <= '0;
      r_trig_prev <= 1'b0;
      r_pend      <= '0;
      r_upd       <= '0;
      r_rst       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], ext_trig_i};
      r_trig_prev <= r_sync[SYNC_STAGES-1];
      r_pend      <= w_pend_next;
      r_upd       <= w_upd_next;
      r_rst       <= w_rst_next;
      r_active    <= w_active_next;
    end
  end

  assign ctrl_active_o    = r_active;
  assign ctrl_update_o    = r_upd;
  assign ctrl_rst_o       = r_rst;
  assign status_state_o   = r_state;
  assign status_pending_o = r_pend;

endmodule

// File: doc/timer_ch_sequencer.md
Name: timer_ch_sequencer

Overview:
- Control sequencer for one advanced-timer instance: generates the active/update/reset strobes that drive the timer counter and its NUM_CH output comparators.
- Decodes software command pulses from the register file and an optional external trigger.
- Applies compare-register updates either immediately or synchronously at the timer period end (shadowed update), and supports one-shot operation.

Parameters:
NUM_CH, 4, number of comparator channels sequenced
SYNC_STAGES, 2, synchroniser depth for ext_trig_i (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmd_start_i  in  1  start pulse
cmd_stop_i  in  1  stop pulse
cmd_update_i  in  1  update request pulse
cmd_reset_i  in  1  counter/comparator reset pulse
cfg_upd_mask_i  in  NUM_CH  channels affected by cmd_update_i
cfg_upd_sync_i  in  1  0 = immediate update, 1 = update at timer end
cfg_trig_en_i  in  1  start waits for external trigger
cfg_oneshot_i  in  1  stop automatically after first timer end
ext_trig_i  in  1  asynchronous external trigger
timer_end_i  in  1  counter end-of-period flag
timer_valid_i  in  1  counter tick qualifier
ctrl_active_o  out  1  counter/comparators enabled
ctrl_update_o  out  NUM_CH  per-channel update strobe, one cycle
ctrl_rst_o  out  1  counter/comparator reset strobe, one cycle
status_state_o  out  2  0 IDLE, 1 WAIT_TRIG, 2 LOAD, 3 RUN
status_pending_o  out  NUM_CH  shadow update pending per channel

Behaviour:
- All outputs registered. Each output changes one cycle after the input that causes it.
- Reset (rst_i=1 at clk edge): state IDLE, all outputs 0, pending 0, synchroniser flops 0, trigger edge register 0.
- Trigger path: ext_trig_i goes through SYNC_STAGES flops, then rising-edge detect. Triggered = synced value 1 and previous synced value 0.
- Command priority within one cycle: cmd_reset_i > cmd_stop_i > cmd_start_i > cmd_update_i. Lower-priority commands in the same cycle are dropped, except that cmd_reset_i and cmd_update_i may both act in the same cycle.
- FSM states and transitions:
  - IDLE: cmd_start with cfg_trig_en=0 -> LOAD; with cfg_trig_en=1 -> WAIT_TRIG.
  - WAIT_TRIG: triggered edge -> LOAD. cmd_stop -> IDLE. cmd_start is ignored.
  - LOAD (exactly 1 cycle):
    - ctrl_update_o = all ones (loads every channel) and ctrl_rst_o = 1, both for that single cycle.
    - Clears all pending bits.
    - Next state is always RUN.
  - RUN: ctrl_active_o = 1 (asserted from the first RUN cycle).
    - cmd_stop -> IDLE; ctrl_active_o deasserts next cycle; all pending bits discarded.
    - cmd_start in RUN is ignored.
  - ctrl_active_o = 1 only in RUN.
- Update handling, RUN only:
  - cmd_update_i is ignored in IDLE and WAIT_TRIG; in those states LOAD always refreshes all channels.
  - cfg_upd_sync=0: ctrl_update_o = cfg_upd_mask_i for one cycle.
  - cfg_upd_sync=1: pending |= cfg_upd_mask_i.
  - On (timer_valid_i & timer_end_i): ctrl_update_o = pending for one cycle and pending clears.
  - cmd_update coincident with a timer-end cycle: its mask is ORed into the strobe at that end, not left pending.
  - Repeated cmd_update before the end: masks accumulate (OR).
- One-shot: in RUN with cfg_oneshot_i=1, (timer_valid_i & timer_end_i) -> IDLE.
  - Any pending update is still strobed on that exit cycle, then pending clears.
- cmd_reset_i, any state: ctrl_rst_o = 1 for one cycle; state and pending unchanged.
  - If the LOAD state and cmd_reset_i coincide, a single ctrl_rst_o pulse is produced.
- Config inputs are sampled every cycle and are not latched.
  - Changing cfg_upd_sync_i from 1 to 0 with pending bits set: those bits are strobed on the next cycle and cleared.
- Simultaneous cmd_stop and timer end in RUN: stop wins and pending is discarded (no update strobe).
- A timer end with timer_valid_i=0 is ignored.
- rst_i asserted mid-operation (any state, including LOAD): next cycle the reset values apply; no partial strobes.

Test Plan:
- Reset then cmd_start (cfg_trig_en=0) -> LOAD next cycle with ctrl_update_o=4'hF and ctrl_rst_o=1; ctrl_active_o=1 one cycle later; status_state_o=3.
- RUN, cfg_upd_sync=1:
  - cmd_update mask 4'b0101, then mask 4'b0010 before the end -> status_pending_o=4'b0111.
  - On timer_end_i & timer_valid_i -> ctrl_update_o=4'b0111 for one cycle, then pending=0.
- cfg_trig_en=1: cmd_start -> WAIT_TRIG.
  - ext_trig_i held high -> LOAD exactly SYNC_STAGES+1 cycles after the sampled rising edge.
  - A second pulse while in RUN -> no effect.
- cfg_oneshot=1 with pending 4'b1000 at the first timer end -> ctrl_update_o=4'b1000, state IDLE, ctrl_active_o=0 the following cycle.
- Same-cycle cmd_reset+cmd_stop in RUN -> ctrl_rst_o pulses, state stays RUN.
  - Same-cycle cmd_stop and timer end with pending 4'b0001 -> IDLE, no update strobe.
- Assert rst_i during LOAD -> next cycle all outputs 0 and state IDLE. A subsequent cmd_start sequences normally.
